// File: rtl/nanoV_spi_pkg.sv
// Shared definitions for the nanoV serial memory bus: opcodes, address length, responder states.
package nanoV_spi_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam int unsigned SPI_ADDR_LEN = 24;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StRead,
        StWrite,
        StIgnore
    } spi_state_e;

endpackage

// File: rtl/spi_ram_array.sv
// Byte array backing the SPI RAM responder: one synchronous write port, one asynchronous read port.
module spi_ram_array #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [7:0]           rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [7:0] mem [DEPTH];

    // Contents are deliberately not reset; programs arrive via the backdoor port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/spi_ram_responder.sv
// Memory-side SPI SRAM responder for the nanoV bus: decodes READ/WRITE commands against an
// internal byte array, with a backdoor load port usable only while the bus is idle.
module spi_ram_responder
    import nanoV_spi_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_select,
    input  logic                 spi_clk_enable,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [7:0]           load_data,
    output logic                 bad_cmd
);

    localparam logic [4:0] ADDR_LAST = 5'(SPI_ADDR_LEN - 1);

    spi_state_e           state;
    logic [4:0]           bit_cnt;
    logic [7:0]           shift;
    logic                 is_read;
    logic [ADDR_BITS-1:0] addr;

    logic [7:0]           shift_next;
    logic [ADDR_BITS-1:0] addr_shift;
    logic [ADDR_BITS-1:0] addr_inc;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [7:0]           rdata;
    logic [2:0]           rd_bit;
    logic                 spi_we;
    logic                 load_fire;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_waddr;
    logic [7:0]           mem_wdata;

    assign shift_next = {shift[6:0], spi_mosi};
    assign addr_shift = {addr[ADDR_BITS-2:0], spi_mosi};
    assign addr_inc   = addr + ADDR_BITS'(1);
    assign rd_bit     = 3'd6 - bit_cnt[2:0];

    // Look ahead so the first bit of a byte can be registered on the edge that selects it.
    always_comb begin
        rd_addr = addr;
        if (state == StAddr) begin
            rd_addr = addr_shift;
        end else if (state == StRead && bit_cnt == 5'd7) begin
            rd_addr = addr_inc;
        end
    end

    assign load_ready = !rst && state == StIdle && spi_select;
    assign load_fire  = load_valid && load_ready;
    assign spi_we     = state == StWrite && !spi_select && spi_clk_enable && bit_cnt == 5'd7;

    // The backdoor is only ready in IDLE, so the two write sources are mutually exclusive.
    assign mem_we    = spi_we || load_fire;
    assign mem_waddr = spi_we ? addr : load_addr;
    assign mem_wdata = spi_we ? shift_next : load_data;

    spi_ram_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .waddr(mem_waddr),
        .wdata(mem_wdata),
        .raddr(rd_addr),
        .rdata(rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            bit_cnt  <= 5'd0;
            shift    <= 8'd0;
            is_read  <= 1'b0;
            addr     <= '0;
            spi_miso <= 1'b0;
            bad_cmd  <= 1'b0;
        end else begin
            bad_cmd <= 1'b0;
            if (spi_select) begin
                state    <= StIdle;
                bit_cnt  <= 5'd0;
                shift    <= 8'd0;
                spi_miso <= 1'b0;
            end else if (spi_clk_enable) begin
                unique case (state)
                    StIdle: begin
                        state   <= StCmd;
                        shift   <= {7'd0, spi_mosi};
                        bit_cnt <= 5'd1;
                    end
                    StCmd: begin
                        shift <= shift_next;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= 5'd0;
                            is_read <= shift_next == SPI_CMD_READ;
                            if (shift_next == SPI_CMD_READ || shift_next == SPI_CMD_WRITE) begin
                                state <= StAddr;
                            end else begin
                                state   <= StIgnore;
                                bad_cmd <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    StAddr: begin
                        addr <= addr_shift;
                        if (bit_cnt == ADDR_LAST) begin
                            bit_cnt <= 5'd0;
                            if (is_read) begin
                                state    <= StRead;
                                spi_miso <= rdata[7];
                            end else begin
                                state <= StWrite;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    StRead: begin
                        if (bit_cnt == 5'd7) begin
                            addr     <= addr_inc;
                            bit_cnt  <= 5'd0;
                            spi_miso <= rdata[7];
                        end else begin
                            spi_miso <= rdata[rd_bit];
                            bit_cnt  <= bit_cnt + 5'd1;
                        end
                    end
                    StWrite: begin
                        shift <= shift_next;
                        if (bit_cnt == 5'd7) begin
                            addr    <= addr_inc;
                            bit_cnt <= 5'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    StIgnore: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: bus transactions against hand-computed byte streams.
module tb_spi_ram_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_select = 1'b1;
    logic       spi_clk_enable = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [9:0] load_addr = 10'd0;
    logic [7:0] load_data = 8'd0;
    logic       bad_cmd;

    int checks = 0;
    int failures = 0;

    logic [7:0]  rb;
    logic [31:0] w;
    logic        acc;

    always #5 clk = ~clk;

    spi_ram_responder #(
        .ADDR_BITS(10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .spi_select    (spi_select),
        .spi_clk_enable(spi_clk_enable),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .bad_cmd       (bad_cmd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        spi_select     = 1'b0;
        spi_clk_enable = 1'b1;
        spi_mosi       = b;
        tick();
        spi_clk_enable = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        send_byte(cmd);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic read_byte(output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            b[i] = spi_miso;
            send_bit(1'b0);
        end
    endtask

    task automatic deselect();
        spi_select     = 1'b1;
        spi_clk_enable = 1'b0;
        tick();
    endtask

    task automatic bd_load(input logic [9:0] a, input logic [7:0] d);
        load_addr  = a;
        load_data  = d;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        check("rst_miso", {31'd0, spi_miso}, 32'd0);
        check("rst_bad_cmd", {31'd0, bad_cmd}, 32'd0);
        rst = 1'b0;
        tick();
        check("ready_idle", {31'd0, load_ready}, 32'd1);
        spi_select = 1'b0;
        #1;
        check("ready_selected", {31'd0, load_ready}, 32'd0);
        spi_select = 1'b1;
        tick();

        // Program preload and streaming read
        bd_load(10'h000, 8'h13);
        bd_load(10'h001, 8'h05);
        bd_load(10'h002, 8'h00);
        bd_load(10'h003, 8'h00);
        send_hdr(8'h03, 24'h000000);
        check("rd_first_bit", {31'd0, spi_miso}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            read_byte(rb);
            w = {w[23:0], rb};
        end
        check("rd_stream", w, 32'h13050000);
        deselect();
        check("deselect_miso", {31'd0, spi_miso}, 32'd0);

        // Two-byte write then read back
        send_hdr(8'h02, 24'h000010);
        send_byte(8'hA5);
        send_byte(8'h3C);
        deselect();
        send_hdr(8'h03, 24'h000010);
        read_byte(rb);
        check("wr_rd_b0", {24'd0, rb}, 32'hA5);
        read_byte(rb);
        check("wr_rd_b1", {24'd0, rb}, 32'h3C);
        deselect();

        // Write streaming across the top address wraps to 0
        send_hdr(8'h02, 24'h0003FF);
        send_byte(8'h11);
        send_byte(8'h22);
        deselect();
        send_hdr(8'h03, 24'h0003FF);
        read_byte(rb);
        check("wrap_top", {24'd0, rb}, 32'h11);
        read_byte(rb);
        check("wrap_rd_zero", {24'd0, rb}, 32'h22);
        deselect();
        send_hdr(8'h03, 24'h000000);
        read_byte(rb);
        check("wrap_wr_zero", {24'd0, rb}, 32'h22);
        deselect();

        // Partial write byte is discarded on deselect
        bd_load(10'h020, 8'h5A);
        send_hdr(8'h02, 24'h000020);
        for (int k = 0; k < 5; k++) send_bit(1'b1);
        deselect();
        send_hdr(8'h03, 24'h000020);
        read_byte(rb);
        check("partial_discard", {24'd0, rb}, 32'h5A);
        deselect();

        // Unsupported command: single bad_cmd pulse, miso silent
        for (int i = 7; i >= 1; i--) send_bit(w[0] | 1'b0 ? 1'b0 : 1'b0);
        deselect();
        rb = 8'h9F;
        for (int i = 7; i >= 1; i--) send_bit(rb[i]);
        check("bad_cmd_early", {31'd0, bad_cmd}, 32'd0);
        send_bit(rb[0]);
        check("bad_cmd_pulse", {31'd0, bad_cmd}, 32'd1);
        acc = 1'b0;
        for (int k = 0; k < 40; k++) begin
            send_bit(1'b1);
            acc = acc | spi_miso;
            if (k == 0) check("bad_cmd_width", {31'd0, bad_cmd}, 32'd0);
        end
        check("ignore_miso", {31'd0, acc}, 32'd0);
        deselect();
        send_hdr(8'h03, 24'h000010);
        read_byte(rb);
        check("after_bad_rd", {24'd0, rb}, 32'hA5);
        deselect();

        // Clock-enable gap mid-byte: miso holds, no bit lost
        send_hdr(8'h03, 24'h000010);
        rb[7] = spi_miso;
        send_bit(1'b0);
        rb[6] = spi_miso;
        send_bit(1'b0);
        for (int k = 0; k < 3; k++) begin
            spi_select     = 1'b0;
            spi_clk_enable = 1'b0;
            tick();
            check("gap_hold", {31'd0, spi_miso}, 32'd1);
        end
        for (int i = 5; i >= 0; i--) begin
            rb[i] = spi_miso;
            send_bit(1'b0);
        end
        check("gap_byte0", {24'd0, rb}, 32'hA5);
        read_byte(rb);
        check("gap_byte1", {24'd0, rb}, 32'h3C);
        deselect();

        // Backdoor blocked while selected, accepted the cycle after deselect
        bd_load(10'h040, 8'h55);
        load_addr  = 10'h040;
        load_data  = 8'h77;
        load_valid = 1'b1;
        send_hdr(8'h03, 24'h000040);
        check("bd_blocked_ready", {31'd0, load_ready}, 32'd0);
        read_byte(rb);
        check("bd_blocked_mem", {24'd0, rb}, 32'h55);
        deselect();
        check("bd_ready_after", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        send_hdr(8'h03, 24'h000040);
        read_byte(rb);
        check("bd_accepted", {24'd0, rb}, 32'h77);
        deselect();

        // Reset mid-read clears miso immediately
        send_hdr(8'h03, 24'h000010);
        check("pre_rst_miso", {31'd0, spi_miso}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
        spi_select = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send_hdr(8'h03, 24'h000010);
        read_byte(rb);
        check("post_rst_rd", {24'd0, rb}, 32'hA5);
        deselect();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_ram_responder.md
# spi_ram_responder

Synthesizable SPI SRAM responder: the memory-side end of the nanoV CPU's serial instruction/data bus. Decodes the 8-bit command, 24-bit address, and data stream the CPU issues on `spi_select` / `spi_out` / `spi_clk_enable`, and serves READ (0x03) and WRITE (0x02) against an internal byte array. Used in simulation benches and FPGA builds in place of an external 23LC-style SRAM. A backdoor load port preloads programs while the bus is idle.

## Interface
- `ADDR_BITS`, default 10: byte-address width of the internal array, giving 2^ADDR_BITS bytes.

- `clk`  in  1: sole clock; also the SPI bit clock, qualified by `spi_clk_enable`.
- `rst`  in  1: asynchronous, active-high reset.
- `spi_select`  in  1: chip select, active low; connects to CPU `spi_select`.
- `spi_clk_enable`  in  1: a bit is transferred only on edges where this is high.
- `spi_mosi`  in  1: command/address/write data, MSB first; connects to CPU `spi_out`.
- `spi_miso`  out  1: registered read data, MSB first; connects to CPU `spi_data_in`.
- `load_valid`  in  1: backdoor write request.
- `load_ready`  out  1: backdoor accepted this cycle when high together with `load_valid`.
- `load_addr`  in  ADDR_BITS: backdoor byte address.
- `load_data`  in  8: backdoor byte.
- `bad_cmd`  out  1: one-cycle pulse when an unsupported command byte completes.

## Operation
- A "bit edge" is a posedge `clk` with `spi_select`=0 and `spi_clk_enable`=1. `spi_mosi` is sampled only on bit edges.
- States:
  - IDLE → CMD on the first bit edge. That bit is command bit 7.
  - CMD: 8 bits. Opcode 0x03 or 0x02 → ADDR. Any other opcode → IGNORE with a `bad_cmd` pulse.
  - ADDR: 24 bits, MSB first. Only the low ADDR_BITS bits are kept. On the 24th bit → READ or WRITE.
  - READ: on the edge that samples the last address bit, `spi_miso` <= mem[addr][7]. Each subsequent bit edge shifts the next bit out. After bit 0 of a byte goes out, addr increments and the next edge presents mem[addr+1][7].
  - WRITE: bits are assembled MSB first. On the 8th bit edge of each byte, mem[addr] <= byte and addr increments.
  - IGNORE: holds until deselect; `spi_miso` stays 0.
- Deselect (`spi_select`=1) at any posedge:
  - state → IDLE, bit counters clear;
  - a partial write byte is discarded;
  - `spi_miso` <= 0.
- Address arithmetic is modulo 2^ADDR_BITS. Streaming past the top address wraps to 0.
- `spi_clk_enable`=0 while selected: state, counters, and `spi_miso` hold.
- Backdoor: `load_ready` = (state==IDLE && `spi_select`=1). A write occurs at posedge when `load_valid && load_ready`. SPI writes and backdoor writes therefore never collide.
- Memory contents are not cleared by reset. Initial contents are X unless preloaded.

## Timing
- Reset values: state IDLE, `spi_miso`=0, `bad_cmd`=0, counters 0. `load_ready` follows `spi_select` combinationally once out of reset.
- Read latency: first data bit is valid on `spi_miso` starting the cycle after the 32nd bit edge (cmd+addr). The CPU samples it on the following posedge, with zero dummy cycles.
- `bad_cmd` is high for exactly the one cycle after the 8th command bit edge.
- A write byte is visible to the backdoor/read path the cycle after its 8th bit edge. A READ of that same address in a later transaction returns the new value.
- Reset asserted mid-transaction: immediate return to IDLE, `spi_miso`=0, no pending write committed.
- Read-after-write on the same address within one transaction is impossible, because a transaction is single-direction.

## Structure
- Shared package `nanoV_spi_pkg`: opcode constants `SPI_CMD_READ` = 8'h03 and `SPI_CMD_WRITE` = 8'h02, address length 24, and the state enum.
- Sub-module `spi_ram_array`:
  - 2^ADDR_BITS × 8 array;
  - one write port, muxed between SPI and backdoor by the responder;
  - one asynchronous read port.
- The responder holds the FSM, the 5-bit bit counter, the address register, and the shift registers.

## Test plan
- Backdoor load mem[0..3] = 0x13,0x05,0x00,0x00. Then SPI 0x03 + addr 0x000000 with 32 read bits → `spi_miso` stream 00010011 00000101 0…0, first bit the cycle after the last address bit.
- SPI 0x02 + addr 0x000010, data 0xA5 0x3C, deselect. Then read from 0x000010 → 0xA5 0x3C.
- ADDR_BITS=10: write 0x11 0x22 starting at 0x0003FF → mem[0x3FF]=0x11, mem[0x000]=0x22.
- Write 0x02 + addr 0x20, then 5 bits of 0xFF, then deselect → mem[0x20] unchanged. Next transaction starts cleanly in CMD.
- Command 0x9F → `bad_cmd` single pulse after the 8th bit. `spi_miso`=0 for 40 further bit edges. Next transaction with 0x03 works.
- Read with `spi_clk_enable` toggled low for 3 cycles mid-byte → `spi_miso` holds and the stream resumes without bit loss.
- `load_valid` held while `spi_select`=0 → `load_ready`=0 and memory unchanged. Write is accepted the cycle after deselect.
